// File: rtl/centurion_io.sv
// Centurion I/O block: LED latch plus a memory-mapped 8N1 UART with a simple interrupt request.
module centurion_io #(
    parameter int unsigned CLKS_PER_BIT = 703,
    parameter logic [18:0] LED_ADDR     = 19'h0F110,
    parameter logic [18:0] MUX_BASE     = 19'h0F200
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        selected,
    output logic [7:0]  leds,
    input  logic        rx_in,
    output logic        tx_out,
    output logic        int_reqn,
    output logic [3:0]  irq_number
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF  = (CLKS_PER_BIT >= 2) ? CLKS_PER_BIT / 2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    // Address decode
    logic [18:0] w_off;
    logic        w_sel_led, w_sel_mux;
    logic        w_rd_status, w_rd_data, w_wr_data, w_wr_intctl, w_wr_vector;

    assign w_off       = address - MUX_BASE;
    assign w_sel_led   = (address == LED_ADDR);
    assign w_sel_mux   = (w_off < 19'd4);
    assign selected    = w_sel_led | w_sel_mux;
    assign w_rd_status = read_en  & w_sel_mux & (w_off[1:0] == 2'd0);
    assign w_rd_data   = read_en  & w_sel_mux & (w_off[1:0] == 2'd1);
    assign w_wr_data   = write_en & w_sel_mux & (w_off[1:0] == 2'd1);
    assign w_wr_intctl = write_en & w_sel_mux & (w_off[1:0] == 2'd2);
    assign w_wr_vector = write_en & w_sel_mux & (w_off[1:0] == 2'd3);

    // Control registers
    logic [7:0] r_leds;
    logic       r_rx_ie, r_tx_ie;
    logic [3:0] r_vector;

    // TX state
    uart_state_t      r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_tx_out;
    logic             w_tx_ready;

    // RX state
    uart_state_t      r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_buf;
    logic             r_rx_sync1, r_rx_sync2, r_rx_prev;
    logic             r_rx_ready, r_framing_err, r_overrun;

    assign w_tx_ready = (r_tx_state == ST_IDLE);

    // CPU-writable LED, interrupt enable and vector registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_leds   <= 8'h00;
            r_rx_ie  <= 1'b0;
            r_tx_ie  <= 1'b0;
            r_vector <= 4'h0;
        end else begin
            if (write_en && w_sel_led) r_leds <= data_in;
            if (w_wr_intctl) begin
                r_rx_ie <= data_in[0];
                r_tx_ie <= data_in[1];
            end
            if (w_wr_vector) r_vector <= data_in[3:0];
        end
    end

    // TX FSM: shifts out start, eight data bits LSB first, then stop
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_out   <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (w_wr_data) begin
                        r_tx_shift <= data_in;
                        r_tx_out   <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                        r_tx_state <= ST_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_out   <= 1'b1;
                            r_tx_state <= ST_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_out   <= r_tx_shift[0];
                            r_tx_shift <= {1'b1, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= ST_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    // RX synchronizer, mid-bit sampling FSM and status flags; new events override read-clears
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rx_sync1    <= 1'b1;
            r_rx_sync2    <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_rx_state    <= ST_IDLE;
            r_rx_cnt      <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_buf      <= '0;
            r_rx_ready    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_rx_sync1 <= rx_in;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
            if (w_rd_data) r_rx_ready <= 1'b0;
            if (w_rd_status) begin
                r_framing_err <= 1'b0;
                r_overrun     <= 1'b0;
            end
            case (r_rx_state)
                ST_IDLE: begin
                    if (r_rx_prev && !r_rx_sync2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_rx_cnt == CNT_HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= ST_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= ST_IDLE;
                        if (r_rx_sync2) begin
                            r_rx_buf   <= r_rx_shift;
                            r_rx_ready <= 1'b1;
                            if (r_rx_ready && !w_rd_data) r_overrun <= 1'b1;
                        end else begin
                            r_framing_err <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    // Read mux, combinational from address
    always_comb begin
        data_out = 8'h00;
        if (w_sel_led) begin
            data_out = r_leds;
        end else if (w_sel_mux) begin
            case (w_off[1:0])
                2'd0:    data_out = {4'b0000, r_overrun, r_framing_err, w_tx_ready, r_rx_ready};
                2'd1:    data_out = r_rx_buf;
                2'd2:    data_out = {6'b000000, r_tx_ie, r_rx_ie};
                default: data_out = {4'b0000, r_vector};
            endcase
        end
    end

    assign leds       = r_leds;
    assign tx_out     = r_tx_out;
    assign irq_number = r_vector;
    assign int_reqn   = ~((r_rx_ie & r_rx_ready) | (r_tx_ie & w_tx_ready));

endmodule

// File: tb/tb_centurion_io.sv
// Directed bench for centurion_io with CLKS_PER_BIT=4 and a scoreboard of expected read data / TX bits.
module tb_centurion_io;
    localparam int unsigned CPB = 4;
    localparam logic [18:0] A_LED    = 19'h0F110;
    localparam logic [18:0] A_STATUS = 19'h0F200;
    localparam logic [18:0] A_DATA   = 19'h0F201;
    localparam logic [18:0] A_INTCTL = 19'h0F202;
    localparam logic [18:0] A_VECTOR = 19'h0F203;

    logic        clock = 1'b0;
    logic        resetn;
    logic [18:0] address;
    logic        write_en, read_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        selected;
    logic [7:0]  leds;
    logic        rx_in;
    logic        tx_out;
    logic        int_reqn;
    logic [3:0]  irq_number;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];
    logic       tx_q[$];

    centurion_io #(.CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .address    (address),
        .write_en   (write_en),
        .read_en    (read_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .selected   (selected),
        .leds       (leds),
        .rx_in      (rx_in),
        .tx_out     (tx_out),
        .int_reqn   (int_reqn),
        .irq_number (irq_number)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [18:0] a, input logic [7:0] d);
        @(negedge clock);
        address = a; data_in = d; write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
    endtask

    // Read with read_en asserted; compares against the oldest scoreboard entry
    task automatic cpu_read(input string tag, input logic [18:0] a);
        logic [7:0] exp;
        @(negedge clock);
        address = a; read_en = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, data_out);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, data_out, exp);
        end
        @(negedge clock);
        read_en = 1'b0;
    endtask

    // Drive one 8N1 frame on rx_in, then idle long enough for the receiver to finish
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(negedge clock);
            rx_in = bits[b];
            repeat (CPB - 1) @(negedge clock);
        end
        @(negedge clock);
        rx_in = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] txd;
        logic       exp_bit;
        int         b;

        resetn = 1'b0; address = '0; write_en = 1'b0; read_en = 1'b0;
        data_in = 8'h00; rx_in = 1'b1;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Reset state
        chk("rst_leds", leds, 8'h00);
        chk("rst_tx_out", {7'b0, tx_out}, 8'h01);
        chk("rst_int_reqn", {7'b0, int_reqn}, 8'h01);
        chk("rst_irq_number", {4'b0, irq_number}, 8'h00);
        chk("rst_selected_addr0", {7'b0, selected}, 8'h00);
        chk("rst_data_out_addr0", data_out, 8'h00);
        sb_q.push_back(8'h02);
        cpu_read("rst_status", A_STATUS);

        // LED register and decode boundaries
        cpu_write(A_LED, 8'hA5);
        chk("led_value", leds, 8'hA5);
        sb_q.push_back(8'hA5);
        cpu_read("led_readback", A_LED);
        chk("led_selected", {7'b0, selected}, 8'h01);
        cpu_write(19'h0F111, 8'h3C);
        chk("led_neighbor_write", leds, 8'hA5);
        chk("sel_0F111", {7'b0, selected}, 8'h00);
        @(negedge clock); address = 19'h0F204;
        #1;
        chk("sel_0F204", {7'b0, selected}, 8'h00);
        chk("data_0F204", data_out, 8'h00);
        address = 19'h0F203;
        #1;
        chk("sel_0F203", {7'b0, selected}, 8'h01);

        // TX frame of 0x55 with a write attempted mid-frame
        txd = 8'h55;
        for (int k = 0; k < 40; k++) begin
            b = k / 4;
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = txd[b-1];
            tx_q.push_back(exp_bit);
        end
        for (int k = 0; k < 5; k++) tx_q.push_back(1'b1);
        @(negedge clock);
        address = A_DATA; data_in = txd; write_en = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clock);
            if (tx_q.size() != 0) chk($sformatf("tx_bit%0d", k), {7'b0, tx_out}, {7'b0, tx_q.pop_front()});
            if (address == A_STATUS)
                chk($sformatf("tx_ready%0d", k), {7'b0, data_out[1]}, (k >= 40) ? 8'h01 : 8'h00);
            write_en = 1'b0; address = A_STATUS;
            if (k == 10) begin
                address = A_DATA; data_in = 8'hFF; write_en = 1'b1;
            end
        end
        chk("tx_queue_drained", 8'(tx_q.size()), 8'h00);

        // RX frame, read, then overrun
        send_frame(8'h3C, 1'b1);
        sb_q.push_back(8'h03);
        cpu_read("rx_status_ready", A_STATUS);
        sb_q.push_back(8'h3C);
        cpu_read("rx_data", A_DATA);
        sb_q.push_back(8'h02);
        cpu_read("rx_status_cleared", A_STATUS);
        send_frame(8'h81, 1'b1);
        send_frame(8'h7E, 1'b1);
        sb_q.push_back(8'h0B);
        cpu_read("rx_status_overrun", A_STATUS);
        sb_q.push_back(8'h03);
        cpu_read("rx_status_ovr_cleared", A_STATUS);
        sb_q.push_back(8'h7E);
        cpu_read("rx_data_overwritten", A_DATA);

        // Interrupts and vector
        cpu_write(A_INTCTL, 8'h01);
        cpu_write(A_VECTOR, 8'h09);
        chk("irq_number_9", {4'b0, irq_number}, 8'h09);
        chk("int_idle", {7'b0, int_reqn}, 8'h01);
        send_frame(8'hC3, 1'b1);
        chk("int_rx_asserted", {7'b0, int_reqn}, 8'h00);
        sb_q.push_back(8'hC3);
        cpu_read("int_rx_data", A_DATA);
        chk("int_rx_cleared", {7'b0, int_reqn}, 8'h01);
        send_frame(8'h5A, 1'b0);
        chk("int_framing_none", {7'b0, int_reqn}, 8'h01);
        sb_q.push_back(8'h06);
        cpu_read("status_framing", A_STATUS);
        sb_q.push_back(8'h02);
        cpu_read("status_framing_cleared", A_STATUS);
        cpu_write(A_INTCTL, 8'h02);
        chk("int_tx_ready", {7'b0, int_reqn}, 8'h00);
        cpu_write(A_INTCTL, 8'hFF);
        sb_q.push_back(8'h03);
        cpu_read("intctl_mask", A_INTCTL);
        cpu_write(A_VECTOR, 8'hFF);
        sb_q.push_back(8'h0F);
        cpu_read("vector_mask", A_VECTOR);
        chk("irq_number_f", {4'b0, irq_number}, 8'h0F);
        cpu_write(A_INTCTL, 8'h00);
        chk("int_disabled", {7'b0, int_reqn}, 8'h01);

        // Reset in the middle of a TX frame
        cpu_write(A_DATA, 8'hF0);
        repeat (5) @(negedge clock);
        chk("tx_mid_frame_low", {7'b0, tx_out}, 8'h00);
        resetn = 1'b0;
        #1;
        chk("rst_mid_tx_out", {7'b0, tx_out}, 8'h01);
        chk("rst_mid_leds", leds, 8'h00);
        chk("rst_mid_irq", {4'b0, irq_number}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        sb_q.push_back(8'h02);
        cpu_read("rst_mid_status", A_STATUS);
        chk("rst_mid_int_reqn", {7'b0, int_reqn}, 8'h01);
        chk("scoreboard_drained", 8'(sb_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/centurion_io.md
CENTURION_IO -- requirements
Module: centurion_io

Interface
REQ-001 Parameter CLKS_PER_BIT, default 703, clock cycles per UART bit (6.75 MHz / 9600 baud).
REQ-002 Parameter LED_ADDR, default 19'h0F110, LED register address.
REQ-003 Parameter MUX_BASE, default 19'h0F200, base of 16-byte serial window.
REQ-004 clock  in  1  single system clock; all logic on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 address  in  19  CPU address bus.
REQ-007 write_en  in  1  CPU write strobe, one cycle per write.
REQ-008 read_en  in  1  CPU read strobe, one cycle per read; enables read side effects.
REQ-009 data_in  in  8  CPU write data.
REQ-010 data_out  out  8  read data, combinational from address.
REQ-011 selected  out  1  high when address hits LED_ADDR or MUX_BASE..MUX_BASE+3.
REQ-012 leds  out  8  LED register (active-high; board inverts).
REQ-013 rx_in  in  1  UART serial input, idle high, asynchronous.
REQ-014 tx_out  out  1  UART serial output, idle high.
REQ-015 int_reqn  out  1  interrupt request, active-low.
REQ-016 irq_number  out  4  interrupt level presented with int_reqn.

Function
REQ-017 Decode is full 19-bit equality; offsets MUX_BASE+4..+15 are unselected (data_out 8'h00, writes ignored).
REQ-018 LED: write_en at LED_ADDR loads leds<=data_in at that edge; read returns leds.
REQ-019 Offset 0 STATUS (read): bit0 rx_ready, bit1 tx_ready(=not busy), bit2 framing_err, bit3 overrun, bits7:4 zero; writes ignored.
REQ-020 Offset 1 DATA: read returns rx byte; read_en clears rx_ready next edge; write_en loads tx byte and starts frame if tx_ready, ignored if busy.
REQ-021 Offset 2 INTCTL (r/w): bit0 rx_ie, bit1 tx_ie, other bits read zero.
REQ-022 Offset 3 VECTOR (r/w): bits3:0 drive irq_number, bits7:4 read zero.
REQ-023 read_en on STATUS clears framing_err and overrun next edge; a same-edge new event wins (flag stays set).
REQ-024 TX frame 8N1: start bit 0, data LSB first, stop bit 1, each exactly CLKS_PER_BIT cycles; tx_out low from edge after the write; tx_ready low the whole 10-bit frame, high again after stop bit.
REQ-025 RX: rx_in via 2-flop synchronizer; falling edge in idle starts frame; sample at bit middle (CLKS_PER_BIT/2 after start edge, then every CLKS_PER_BIT); start bit sampled high is a glitch, return to idle.
REQ-026 RX stop sampled 1: byte to rx buffer, rx_ready=1; if rx_ready already set, overwrite and set overrun.
REQ-027 RX stop sampled 0: byte discarded, framing_err=1, rx_ready unchanged.
REQ-028 RX FSM states IDLE, START, DATA, STOP; TX FSM states IDLE, START, DATA, STOP; both return to IDLE after STOP.
REQ-029 int_reqn = NOT((rx_ie AND rx_ready) OR (tx_ie AND tx_ready)), combinational from registers.
REQ-030 Simultaneous RX completion and read_en of DATA: new byte loaded, rx_ready stays 1, no overrun.

Reset
REQ-031 resetn low asynchronously forces: leds=0, tx_out=1, TX/RX FSMs IDLE, rx_ready=0, framing_err=0, overrun=0, INTCTL=0, VECTOR=0, rx buffer=0, bit counters=0.
REQ-032 After reset: STATUS reads 8'h02, int_reqn=1, irq_number=0; reset during a frame aborts it with no partial byte delivered.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-033 Reset release -> leds=00, tx_out=1, int_reqn=1, STATUS read=8'h02, selected=0 at address 0.
REQ-034 Write A5 to 0x0F110 -> leds=A5 next edge, read 0x0F110=A5; write to 0x0F111 -> leds unchanged, selected=0.
REQ-035 Write 55 to 0x0F201 -> tx_out 0,1,0,1,0,1,0,1,0,1 each 4 cycles, then 1; STATUS bit1=0 for 40 cycles then 1; second write mid-frame ignored.
REQ-036 Drive frame 3C on rx_in -> STATUS=8'h03; read_en at 0x0F201 returns 3C, STATUS=8'h02; second frame without read -> STATUS bit3=1.
REQ-037 Write 01 to 0x0F202, 09 to 0x0F203, receive byte -> int_reqn=0, irq_number=9; read DATA -> int_reqn=1; frame with stop=0 -> STATUS bit2=1, int_reqn stays 1.
REQ-038 Assert resetn low mid TX frame -> tx_out=1 immediately, STATUS=8'h02, leds=00.
